// File: rtl/dma_op_pkg.sv
// Opcode constants, FSM state encoding and opcode-legality helper for the DMA op engine.
// Defining DMA_OP_ENGINE_XOR_EN makes opcode 3 (XOR) legal.
package dma_op_pkg;

  localparam logic [2:0] OP_READ = 3'd0;
  localparam logic [2:0] OP_FILL = 3'd1;
  localparam logic [2:0] OP_COPY = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
`ifdef DMA_OP_ENGINE_XOR_EN
    return (op <= OP_XOR);
`else
    return (op <= OP_COPY);
`endif
  endfunction

endpackage

// File: rtl/dma_op_xform.sv
// Per-opcode data transform: pass-through, fill pattern, or XOR with the pattern.
// The XOR path exists only when DMA_OP_ENGINE_XOR_EN is defined.
module dma_op_xform
  import dma_op_pkg::*;
#(
  parameter int DW = 64
) (
  input  logic [2:0]    op,
  input  logic [DW-1:0] src,
  input  logic [DW-1:0] pat,
  output logic [DW-1:0] data
);

  always_comb begin
    data = src;
    case (op)
      OP_FILL: data = pat;
`ifdef DMA_OP_ENGINE_XOR_EN
      OP_XOR:  data = src ^ pat;
`endif
      default: data = src;
    endcase
  end

endmodule

// File: rtl/dma_op_engine.sv
// DMA operation engine: READ / FILL / COPY / XOR between FIFO-style ports, all outputs registered.
// Opcode 3 (XOR) is available only when DMA_OP_ENGINE_XOR_EN is defined.
module dma_op_engine
  import dma_op_pkg::*;
#(
  parameter int DW   = 64,
  parameter int CNTW = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            m_enable,
  input  logic [23:0]     dc,
  input  logic [CNTW-1:0] m_len,
  input  logic [DW-1:0]   fill_pat,
  output logic            m_src_getn,
  input  logic [DW-1:0]   m_src,
  input  logic            m_src_last,
  input  logic            m_src_empty,
  input  logic            m_src_almost_empty,
  output logic            m_dst_putn,
  output logic [DW-1:0]   m_dst,
  output logic            m_dst_last,
  input  logic            m_dst_full,
  input  logic            m_dst_almost_full,
  output logic            m_endn,
  output logic            m_err,
  output logic [CNTW-1:0] m_count
);

  state_t          state_reg, state_next;
  logic [2:0]      op_reg, op_next;
  logic [CNTW-1:0] len_reg, len_next;
  logic [DW-1:0]   pat_reg, pat_next;
  logic [CNTW-1:0] count_reg, count_next;
  logic            getn_reg, getn_next;
  logic            putn_reg, putn_next;
  logic            endn_reg, endn_next;
  logic [DW-1:0]   dst_reg, dst_next;
  logic            dst_last_reg, dst_last_next;
  logic            err_reg, err_next;
  logic            valid_reg, valid_next;
  logic            stop_reg, stop_next;

  logic            fo_full;
  logic            pop_ok;
  logic [CNTW-1:0] cnt_inc;
  logic [DW-1:0]   xf_data;
  logic            unused_ok;

  assign unused_ok = ^{dc[23:3], m_src_almost_empty};
  assign fo_full   = m_dst_full | m_dst_almost_full;
  assign cnt_inc   = count_reg + 1'b1;

  // One word in flight at most: no pop while a pop is on the bus or its data is arriving.
  assign pop_ok = m_enable && !m_src_empty && (op_reg == OP_READ || !fo_full)
                  && getn_reg && !valid_reg;

  dma_op_xform #(.DW(DW)) u_xform (
    .op   (op_reg),
    .src  (m_src),
    .pat  (pat_reg),
    .data (xf_data)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg    <= ST_IDLE;
      op_reg       <= OP_READ;
      len_reg      <= '0;
      pat_reg      <= '0;
      count_reg    <= '0;
      getn_reg     <= 1'b1;
      putn_reg     <= 1'b1;
      endn_reg     <= 1'b1;
      dst_reg      <= '0;
      dst_last_reg <= 1'b0;
      err_reg      <= 1'b0;
      valid_reg    <= 1'b0;
      stop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      len_reg      <= len_next;
      pat_reg      <= pat_next;
      count_reg    <= count_next;
      getn_reg     <= getn_next;
      putn_reg     <= putn_next;
      endn_reg     <= endn_next;
      dst_reg      <= dst_next;
      dst_last_reg <= dst_last_next;
      err_reg      <= err_next;
      valid_reg    <= valid_next;
      stop_reg     <= stop_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    len_next      = len_reg;
    pat_next      = pat_reg;
    count_next    = count_reg;
    getn_next     = 1'b1;
    putn_next     = 1'b1;
    endn_next     = 1'b1;
    dst_next      = dst_reg;
    dst_last_next = dst_last_reg;
    err_next      = err_reg;
    valid_next    = !getn_reg;
    stop_next     = stop_reg;

    case (state_reg)
      ST_IDLE: begin
        if (m_enable) begin
          if (!op_legal(dc[2:0])) begin
            state_next = ST_DONE;
            err_next   = 1'b1;
            endn_next  = 1'b0;
          end else if (dc[2:0] == OP_FILL && m_len == '0) begin
            state_next = ST_DONE;
            count_next = '0;
            endn_next  = 1'b0;
          end else begin
            state_next = ST_RUN;
            op_next    = dc[2:0];
            len_next   = m_len;
            pat_next   = fill_pat;
            count_next = '0;
            stop_next  = 1'b0;
          end
        end
      end

      ST_RUN: begin
        if (op_reg == OP_FILL) begin
          if (count_reg == len_reg) begin
            state_next = ST_DONE;
            endn_next  = 1'b0;
          end else if (m_enable && !fo_full) begin
            putn_next     = 1'b0;
            dst_next      = xf_data;
            dst_last_next = (cnt_inc == len_reg);
            count_next    = cnt_inc;
          end
        end else if (stop_reg) begin
          state_next = ST_DONE;
          endn_next  = 1'b0;
        end else begin
          if (pop_ok) begin
            getn_next = 1'b0;
            if (op_reg == OP_READ) count_next = cnt_inc;
          end
          // Source data is valid the cycle after the pop; push it (or drop it for READ) now.
          if (valid_reg) begin
            stop_next = m_src_last;
            if (op_reg != OP_READ) begin
              putn_next     = 1'b0;
              dst_next      = xf_data;
              dst_last_next = m_src_last;
              count_next    = cnt_inc;
            end
          end
        end
      end

      ST_DONE: state_next = ST_HOLD;

      ST_HOLD: begin
        if (!m_enable) begin
          state_next = ST_IDLE;
          err_next   = 1'b0;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign m_src_getn = getn_reg;
  assign m_dst_putn = putn_reg;
  assign m_dst      = dst_reg;
  assign m_dst_last = dst_last_reg;
  assign m_endn     = endn_reg;
  assign m_err      = err_reg;
  assign m_count    = count_reg;

endmodule

// File: doc/dma_op_engine.md
DMA_OP_ENGINE -- requirements
Module: dma_op_engine

Interface
REQ-001 Parameter: DW, default 64, data word width in bits (multiple of 8).
REQ-002 Parameter: CNTW, default 16, width of the fill length and the word counter.
REQ-003 wb_clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-004 wb_rst_i  in  1  reset, synchronous and active-high.
REQ-005 m_enable  in  1  operation enable; level-sensitive.
REQ-006 dc  in  24  descriptor control; dc[2:0] is the opcode, all other bits are ignored.
REQ-007 m_len  in  CNTW  fill length in words; sampled at start.
REQ-008 fill_pat  in  DW  fill/XOR pattern; sampled at start.
REQ-009 m_src_getn  out  1  active-low source pop strobe.
REQ-010 m_src, m_src_last  in  DW, 1  source word and last flag; valid the cycle after a pop.
REQ-011 m_src_empty, m_src_almost_empty  in  1  source FIFO status.
REQ-012 m_dst_putn  out  1  active-low destination push strobe.
REQ-013 m_dst, m_dst_last  out  DW, 1  destination word and last flag.
REQ-014 m_dst_full, m_dst_almost_full  in  1  destination FIFO status.
REQ-015 m_endn  out  1  active-low one-cycle completion pulse.
REQ-016 m_err  out  1  illegal-opcode flag.
REQ-017 m_count  out  CNTW  count of words moved in the current operation.

Function
REQ-018 Opcodes SHALL be: 0 READ (pop and discard), 1 FILL (push fill_pat), 2 COPY (m_dst=m_src), 3 XOR (m_dst=m_src^fill_pat); all others are illegal.
REQ-019 The FSM SHALL have the states IDLE, RUN, DONE and HOLD; all outputs are registered.
REQ-020 IDLE->RUN SHALL occur when m_enable=1 and the opcode is legal; the opcode, m_len and fill_pat are latched and m_count is cleared.
REQ-021 IDLE->DONE SHALL occur when m_enable=1 and the opcode is illegal; m_err is set and nothing is popped or pushed.
REQ-022 Define fo_full = m_dst_full|m_dst_almost_full.
REQ-023 READ/COPY/XOR SHALL pop (getn low for 1 cycle) only when m_src_empty=0, fo_full=0 (READ ignores fo_full), m_enable=1 and no pop is outstanding, giving at most 1 word in flight.
REQ-024 A word popped in cycle t SHALL appear with putn low in cycle t+2, with m_dst_last=m_src_last (not applicable to READ, which never pushes).
REQ-025 A word whose m_src_last=1 SHALL end the operation: no further pops, RUN->DONE after that word is pushed (or discarded).
REQ-026 FILL SHALL push fill_pat in every cycle with fo_full=0 and m_enable=1 until m_len words are pushed, with m_dst_last=1 on the final word.
REQ-027 FILL with m_len=0 SHALL go directly to DONE with no pushes.
REQ-028 m_count SHALL increment per word popped (READ) or pushed (others), wrapping modulo 2^CNTW.
REQ-029 m_enable=0 during RUN SHALL pause new pops and pushes; a word already in flight still completes, and the operation resumes on re-enable.
REQ-030 DONE SHALL drive m_endn low for exactly one cycle, then go to HOLD.
REQ-031 HOLD SHALL persist until m_enable=0, then go to IDLE and clear m_err; this prevents a restart on a still-high enable.

Reset
REQ-032 wb_rst_i=1 at any clock edge, including mid-operation, SHALL force IDLE, getn=putn=endn=1, m_dst=0, m_dst_last=0, m_err=0, m_count=0, and discard any in-flight word.

Configuration
REQ-033 With DMA_OP_ENGINE_XOR_EN defined, opcode 3 SHALL perform XOR.
REQ-034 Without DMA_OP_ENGINE_XOR_EN, opcode 3 SHALL be illegal (REQ-021) and no XOR logic SHALL be synthesised.

Structure
REQ-035 The opcode constants and the state encoding SHALL live in the shared package dma_op_pkg.
REQ-036 The per-opcode data transform (pass, pattern, XOR) SHALL be the sub-module dma_op_xform; the FSM, counters and handshake stay in dma_op_engine.

Verification
REQ-037 COPY of 3 words A,B,C (last on C), FIFOs never full -> pushes A,B,C each 2 cycles after their pop; dst_last on C; m_count=3; one endn pulse.
REQ-038 FILL with m_len=4 and fill_pat=0xDEADBEEF_00C0FFEE, with almost_full asserted for 5 cycles after the 2nd push -> 4 pushes of the pattern, none while fo_full; last on the 4th.
REQ-039 XOR of 0x0F0F... with fill_pat=0xFFFF... -> 0xF0F0...; with the macro undefined -> m_err=1, endn pulse, no pop or push.
REQ-040 READ of 5 words with m_src_empty toggling -> no pops while empty; putn never low; m_count=5.
REQ-041 wb_rst_i for 1 cycle while a COPY word is in flight -> no push; all outputs at reset values the next cycle; a new op starts cleanly.
REQ-042 Opcode 7 with m_enable held high for 10 cycles -> exactly one endn pulse; m_err stays high until m_enable=0.
